sbus_writeback_queue: RTL and testbench
=======================================

# sbus_writeback_queue

Writeback stage that sits directly upstream of the register bank. It accepts register-write requests (destination index plus 16-bit result) from the execute side through a valid/ready handshake and buffers them in a small FIFO. It drains one entry per cycle onto the S bus, together with a one-hot SRx store strobe, so exactly one `switchable_register` captures the value. It also exports a pending-write mask that the issue logic uses for read-after-write hazard stalls.

## Interface
- `NREG`, 8, number of registers, which is also the width of `SR` and `pending_mask`.
- `DEPTH`, 4, number of FIFO entries; must be a power of two, ≥2.
- `DW`, 16, data width of the S bus.
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `CLR`  in  1  reset, synchronous and active-high.
- `wb_valid`  in  1  write request present.
- `wb_ready`  out  1  request accepted on an edge where `wb_valid & wb_ready`.
- `wb_dst`  in  clog2(NREG)  destination register index.
- `wb_data`  in  DW  value to write.
- `hold`  in  1  S bus borrowed by another master; no drain this cycle.
- `S_bus`  out  DW  registered data to the register bank.
- `SR`  out  NREG  registered one-hot store strobes (SR0..SR{NREG-1}).
- `pending_mask`  out  NREG  bit i is set while a write to register i is queued or is being strobed.
- `count`  out  clog2(DEPTH)+1  number of entries in the FIFO.
- `full`, `empty`  out  1  FIFO status, with `full` = (count==DEPTH) and `empty` = (count==0).

## Operation
- **Push:** occurs on an edge with `wb_valid & wb_ready & ~CLR`. The entry {dst, data} is written at the write pointer, and the pointer increments modulo DEPTH.
- **Pop:** occurs on an edge with `~empty & ~hold & ~CLR`.
  - The head entry is removed and the read pointer increments modulo DEPTH.
  - `S_bus` is loaded with the head data.
  - `SR` is loaded with one-hot(head dst).
- **Idle edge (no pop):** `SR` is loaded with all zeros and `S_bus` holds its previous value. The bus is not toggled on idle cycles.
- **Ready rule:** `wb_ready` = `~full | ~hold`.
  - When the FIFO is full, a push is accepted only on an edge where a pop is also occurring.
  - `wb_ready` does not depend on `wb_valid`.
- **Simultaneous push and pop:** both take effect on the same edge and `count` is unchanged. When the FIFO is empty, the pushed entry does not bypass; it becomes head and pops at the earliest on the next edge.
- **Ordering:** strict FIFO order. Multiple entries for the same dst are drained in order, so the last write wins in the register. There is no coalescing.
- **Out-of-range dst:** if `wb_dst` ≥ NREG, the entry is accepted and drained in order with `SR` = 0. It sets no `pending_mask` bit.
- **pending_mask:** the OR over all valid FIFO entries of one-hot(dst), ORed with the current `SR`. It is combinational from registered state. A bit clears in the cycle after the strobe cycle, once the register has captured the value.
- **Reset:** an edge with `CLR` high does the following, and overrides any push or pop on the same edge:
  - pointers set to 0 and `count` set to 0;
  - `SR` set to 0 and `S_bus` set to 0;
  - all queued entries discarded;
  - `pending_mask` reads 0 and `empty` reads 1.

## Timing
- **Outputs during and after reset:** during reset `wb_ready` reads 1 unless `hold` is high.
- **Latency, request to strobe:** a request accepted at edge N, with an empty FIFO and `hold` low, pops at edge N+1. `SR`/`S_bus` are valid during cycle N+1..N+2, and the target register captures the value at edge N+2.
- **Throughput:** one write per cycle sustained with `hold` low, and one drain per cycle.
- **Effect of hold:** each cycle with `hold` high delays the head by one cycle. `SR` is 0 in the cycle following each edge sampled with `hold` high.
- **Strobe width:** `SR` is never high for more than one cycle for the same entry. At most one `SR` bit is high at any time.
- **Wrap-around:** pointers wrap without a gap. Entry DEPTH+1 reuses slot 0 only after slot 0 has been popped.

## Test plan
- **Single write:** reset, then push dst=3, data=0xBEEF at edge 1 with `hold`=0.
  - `SR`=0x08 and `S_bus`=0xBEEF for exactly one cycle after edge 2.
  - `pending_mask`=0x08 from edge 1 until edge 3.
- **Fill under hold:** hold=1 and push 4 entries (dst 0..3, data 0x1111..0x4444).
  - Expect `full`=1, `wb_ready`=0, and a fifth push is not accepted.
  - Release hold; strobes then run on 4 consecutive cycles with SR 0x01, 0x02, 0x04, 0x08 and matching data.
- **Full with simultaneous push/pop:** with the FIFO full and hold=0, push dst=5, data=0xAAAA.
  - Accepted; `count` stays 4.
  - 0xAAAA is strobed as the 5th drain, with SR=0x20.
- **Same-dst ordering and wrap:** 10 back-to-back pushes to dst=7 with data 0..9, with hold toggling every other cycle.
  - Drains in order 0..9 with no loss.
  - `pending_mask[7]` stays set until the strobe of value 9 ends.
- **Reset mid-operation:** 3 entries queued and an `SR` strobe active; assert CLR for one edge.
  - Next cycle: SR=0, S_bus=0, count=0, empty=1, pending_mask=0.
  - No further strobes occur.
- **Out-of-range dst:** with NREG=6, push dst=7.
  - Accepted, `count` increments, and the drain cycle shows SR=0.
  - `pending_mask` is unaffected.

Source files
------------

// File: rtl/sbus_writeback_queue.sv
// Writeback queue feeding the register bank over the S bus.
// Buffers {dst, data} requests and drains one per cycle with a one-hot SR store strobe.
module sbus_writeback_queue #(
  parameter  int NREG  = 8,
  parameter  int DEPTH = 4,
  parameter  int DW    = 16,
  localparam int DST_W = (NREG > 1) ? $clog2(NREG) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [DST_W-1:0] wb_dst,
  input  logic [DW-1:0]    wb_data,
  input  logic             hold,
  output logic [DW-1:0]    S_bus,
  output logic [NREG-1:0]  SR,
  output logic [NREG-1:0]  pending_mask,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DST_W-1:0] dst_q  [DEPTH];
  logic [DST_W-1:0] dst_d  [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [NREG-1:0]  sr_q, sr_d;
  logic [DW-1:0]    s_bus_q, s_bus_d;
  logic             push;
  logic             pop;

  // Indices at or above NREG map to an all-zero strobe.
  function automatic logic [NREG-1:0] dst_onehot(input logic [DST_W-1:0] dst);
    logic [NREG-1:0] oh;
    oh = '0;
    for (int i = 0; i < NREG; i++) begin
      oh[i] = (int'(dst) == i);
    end
    return oh;
  endfunction

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  // A full queue can still accept when the head leaves on the same edge.
  assign wb_ready = ~full | ~hold;
  assign push     = wb_valid & wb_ready;
  assign pop      = ~empty & ~hold;

  always_comb begin
    dst_d    = dst_q;
    data_d   = data_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sr_d     = '0;
    s_bus_d  = s_bus_q;

    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
      sr_d            = dst_onehot(dst_q[rd_ptr_q]);
      s_bus_d         = data_q[rd_ptr_q];
    end

    // Push after pop so a full-queue swap on the same slot leaves it valid.
    if (push) begin
      dst_d[wr_ptr_q]  = wb_dst;
      data_d[wr_ptr_q] = wb_data;
      vld_d[wr_ptr_q]  = 1'b1;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sr_q     <= '0;
      s_bus_q  <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sr_q     <= sr_d;
      s_bus_q  <= s_bus_d;
    end
  end

  // Slot storage is qualified by vld_q, so it needs no reset.
  always_ff @(posedge CLK) begin
    dst_q  <= dst_d;
    data_q <= data_d;
  end

  always_comb begin
    pending_mask = sr_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) pending_mask = pending_mask | dst_onehot(dst_q[i]);
    end
  end

  assign S_bus = s_bus_q;
  assign SR    = sr_q;
  assign count = count_q;

endmodule

// File: tb/tb_sbus_writeback_queue.sv
// Bench for sbus_writeback_queue: NREG=8 and NREG=6 instances share one stimulus stream
// and are compared each cycle against a queue-based reference model.
module tb_sbus_writeback_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        wb_valid = 1'b0;
  logic [2:0]  wb_dst = '0;
  logic [15:0] wb_data = '0;
  logic        hold = 1'b0;

  logic        ready8, ready6, full8, full6, empty8, empty6;
  logic [15:0] sbus8, sbus6;
  logic [7:0]  sr8, pm8;
  logic [5:0]  sr6, pm6;
  logic [2:0]  count8, count6;

  always #5 clk = ~clk;

  sbus_writeback_queue #(.NREG(8), .DEPTH(DEPTH), .DW(16)) dut8 (
    .CLK(clk), .CLR(clr), .wb_valid(wb_valid), .wb_ready(ready8), .wb_dst(wb_dst),
    .wb_data(wb_data), .hold(hold), .S_bus(sbus8), .SR(sr8), .pending_mask(pm8),
    .count(count8), .full(full8), .empty(empty8));

  sbus_writeback_queue #(.NREG(6), .DEPTH(DEPTH), .DW(16)) dut6 (
    .CLK(clk), .CLR(clr), .wb_valid(wb_valid), .wb_ready(ready6), .wb_dst(wb_dst),
    .wb_data(wb_data), .hold(hold), .S_bus(sbus6), .SR(sr6), .pending_mask(pm6),
    .count(count6), .full(full6), .empty(empty6));

  typedef struct {
    logic [2:0]  dst;
    logic [15:0] data;
  } ent_t;

  ent_t        mq[$];
  bit          m_sr_vld = 1'b0;
  logic [2:0]  m_sr_dst = '0;
  logic [15:0] m_sbus = '0;
  bit          model_ok = 1'b0;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_oh(input logic [2:0] d, input int n);
    if (int'(d) < n) return 8'(1) << d;
    return 8'h00;
  endfunction

  function automatic logic [7:0] exp_sr(input int n);
    return m_sr_vld ? exp_oh(m_sr_dst, n) : 8'h00;
  endfunction

  function automatic logic [7:0] exp_pm(input int n);
    logic [7:0] m;
    m = exp_sr(n);
    foreach (mq[i]) m = m | exp_oh(mq[i].dst, n);
    return m;
  endfunction

  // One clock: drive at negedge, compare against model, advance model at posedge.
  task automatic step(input bit c, input bit v, input logic [2:0] d, input logic [15:0] x,
                      input bit h, output bit acc);
    bit   m_full, m_ready, m_pop;
    ent_t e;
    @(negedge clk);
    clr = c; wb_valid = v; wb_dst = d; wb_data = x; hold = h;
    #1;
    m_full  = (mq.size() == DEPTH);
    m_ready = !m_full || !h;
    m_pop   = (mq.size() != 0) && !h;
    acc     = v && m_ready && !c;
    if (model_ok) begin
      check("ready8", ready8, m_ready);
      check("ready6", ready6, m_ready);
      check("count8", count8, mq.size());
      check("count6", count6, mq.size());
      check("full8", full8, m_full);
      check("empty8", empty8, mq.size() == 0);
      check("empty6", empty6, mq.size() == 0);
      check("sbus8", sbus8, m_sbus);
      check("sbus6", sbus6, m_sbus);
      check("sr8", sr8, exp_sr(8));
      check("sr6", sr6, exp_sr(6));
      check("pm8", pm8, exp_pm(8));
      check("pm6", pm6, exp_pm(6));
    end
    @(posedge clk);
    if (c) begin
      mq.delete();
      m_sr_vld = 1'b0;
      m_sbus   = '0;
      model_ok = 1'b1;
    end else begin
      if (m_pop) begin
        e = mq.pop_front();
        m_sr_vld = 1'b1;
        m_sr_dst = e.dst;
        m_sbus   = e.data;
      end else begin
        m_sr_vld = 1'b0;
      end
      if (acc) mq.push_back('{d, x});
    end
    #1;
  endtask

  initial begin
    bit          acc;
    int          sent, guard;
    logic [15:0] got_q[$];
    logic [7:0]  exp_sr_seq[5];
    logic [15:0] exp_dat_seq[5];

    // Reset
    step(1, 0, 0, 0, 0, acc);
    check("rst_count", count8, 0);
    check("rst_empty", empty8, 1);
    check("rst_ready", ready8, 1);
    check("rst_pm", pm8, 0);
    check("rst_sbus", sbus8, 0);

    // Single write
    step(0, 1, 3, 16'hBEEF, 0, acc);
    check("single_pm_e1", pm8, 8'h08);
    check("single_sr_e1", sr8, 8'h00);
    step(0, 0, 0, 0, 0, acc);
    check("single_sr_e2", sr8, 8'h08);
    check("single_sbus_e2", sbus8, 16'hBEEF);
    check("single_pm_e2", pm8, 8'h08);
    step(0, 0, 0, 0, 0, acc);
    check("single_sr_e3", sr8, 8'h00);
    check("single_pm_e3", pm8, 8'h00);
    check("single_sbus_hold", sbus8, 16'hBEEF);

    // Fill under hold, rejected fifth push, then full swap
    for (int i = 0; i < 4; i++) step(0, 1, 3'(i), 16'(16'h1111 * (i + 1)), 1, acc);
    check("fill_full", full8, 1);
    check("fill_ready", ready8, 0);
    step(0, 1, 6, 16'h5555, 1, acc);
    check("fifth_acc", acc, 0);
    check("fifth_count", count8, 4);
    step(0, 1, 5, 16'hAAAA, 0, acc);
    check("swap_acc", acc, 1);
    check("swap_count", count8, 4);
    check("swap_sr", sr8, 8'h01);
    check("swap_sbus", sbus8, 16'h1111);
    exp_sr_seq  = '{8'h02, 8'h04, 8'h08, 8'h20, 8'h00};
    exp_dat_seq = '{16'h2222, 16'h3333, 16'h4444, 16'hAAAA, 16'hAAAA};
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, acc);
      check("drain_sr", sr8, exp_sr_seq[i]);
      check("drain_sbus", sbus8, exp_dat_seq[i]);
    end
    check("drain_empty", empty8, 1);

    // Same-dst ordering with hold toggling every other cycle
    sent = 0;
    guard = 0;
    while (sent < 10 && guard < 60) begin
      step(0, 1, 7, 16'(sent), ((guard / 2) % 2) == 1, acc);
      if (acc) sent++;
      if (sr8[7]) got_q.push_back(sbus8);
      check("same_pm7", pm8[7], 1);
      guard++;
    end
    while (got_q.size() < 10 && guard < 100) begin
      step(0, 0, 0, 0, ((guard / 2) % 2) == 1, acc);
      if (sr8[7]) got_q.push_back(sbus8);
      check("same_pm7", pm8[7], 1);
      guard++;
    end
    check("same_sent", sent, 10);
    check("same_drained", got_q.size(), 10);
    foreach (got_q[i]) check("same_order", got_q[i], i);
    step(0, 0, 0, 0, 0, acc);
    check("same_pm7_clear", pm8[7], 0);

    // Reset mid-operation with a strobe active
    step(0, 1, 1, 16'h0101, 1, acc);
    step(0, 1, 2, 16'h0202, 1, acc);
    step(0, 1, 4, 16'h0404, 1, acc);
    step(0, 1, 6, 16'h0606, 1, acc);
    step(0, 0, 0, 0, 0, acc);
    check("mid_sr", sr8, 8'h02);
    check("mid_count", count8, 3);
    step(1, 0, 0, 0, 0, acc);
    check("clr_sr", sr8, 0);
    check("clr_sbus", sbus8, 0);
    check("clr_count", count8, 0);
    check("clr_empty", empty8, 1);
    check("clr_pm", pm8, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, acc);
      check("clr_no_strobe", sr8, 0);
    end

    // Out-of-range dst on the NREG=6 instance
    step(0, 1, 7, 16'h7777, 0, acc);
    check("oor_count6", count6, 1);
    check("oor_pm6", pm6, 0);
    check("oor_pm8", pm8, 8'h80);
    step(0, 0, 0, 0, 0, acc);
    check("oor_sr6", sr6, 0);
    check("oor_sr8", sr8, 8'h80);
    check("oor_sbus6", sbus6, 16'h7777);
    check("oor_count6_drained", count6, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
           16'($urandom), $urandom_range(0, 2) == 0, acc);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
